fetch_prefetch_queue: RTL and testbench

//  Instruction prefetch unit feeding the IF/ID register of the 5-stage core; replaces direct PC->InstructionMemory path.

---
 rtl/fetch_prefetch_queue_if.sv | 25 ++
 rtl/fetch_prefetch_queue.sv | 151 +++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Prefetch queue bus bundle: instruction-memory request/response, fetch redirect and IF/ID delivery.
// The master modport is the prefetch unit; the slave modport is the memory/core side.
interface fetch_prefetch_queue_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
      output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: in-order fetch to variable-latency memory, PC/instr FIFO to IF/ID, redirect flush.
// Optional PFQ_BYPASS_EN: a response arriving at an empty queue is presented to IF/ID in the same cycle.
module fetch_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                    clk,
   input logic                    reset,
   fetch_prefetch_queue_if.master bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

   logic [31:0]      fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [31:0]      pc_mem_q [DEPTH];
   logic [31:0]      pc_mem_d [DEPTH];
   logic [31:0]      instr_mem_q [DEPTH];
   logic [31:0]      instr_mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;

   logic             req_valid_s, req_fire_s, resp_keep_s, bypass_s, push_s, pop_s, if_valid_s;
   logic [31:0]      if_pc_s, if_instr_s, redirect_pc_s;
   logic [CNT_W:0]   credit_sum_s;

   // Handshake decode: request credit, response steering, IF/ID presentation and pop.
   always_comb begin
      credit_sum_s  = {1'b0, count_q} + {1'b0, inflight_q};
      redirect_pc_s = bus.redirect_pc & 32'hFFFF_FFFC;
      // Outstanding requests plus buffered entries never exceed DEPTH, so a kept response always fits.
      req_valid_s   = !reset && !bus.redirect_valid && (credit_sum_s < DEPTH_SUM);
      req_fire_s    = req_valid_s && bus.imem_req_ready;
      resp_keep_s   = bus.imem_resp_valid && (drop_q == CNT_ZERO) && !bus.redirect_valid;
      if_valid_s    = 1'b0;
      if_pc_s       = pc_mem_q[rd_ptr_q];
      if_instr_s    = instr_mem_q[rd_ptr_q];
      bypass_s      = 1'b0;
`ifdef PFQ_BYPASS_EN
      if ((count_q == CNT_ZERO) && resp_keep_s) begin
         if_valid_s = !reset;
         if_pc_s    = resp_pc_q;
         if_instr_s = bus.imem_resp_data;
         bypass_s   = bus.if_ready;
      end else begin
         if_valid_s = !reset && !bus.redirect_valid && (count_q != CNT_ZERO);
         if_pc_s    = pc_mem_q[rd_ptr_q];
         if_instr_s = instr_mem_q[rd_ptr_q];
         bypass_s   = 1'b0;
      end
`else
      if_valid_s = !reset && !bus.redirect_valid && (count_q != CNT_ZERO);
`endif
      push_s = resp_keep_s && !bypass_s;
      pop_s  = (count_q != CNT_ZERO) && !bus.redirect_valid && bus.if_ready;
   end

   // Next-state computation; a redirect overrides every other update in its cycle.
   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      resp_pc_d   = resp_pc_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      inflight_d  = inflight_q;
      drop_d      = drop_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = redirect_pc_s;
         resp_pc_d  = redirect_pc_s;
         count_d    = CNT_ZERO;
         rd_ptr_d   = wr_ptr_q;
         // Everything still outstanding is wrong-path; a response landing now is discarded too.
         inflight_d = inflight_q - (bus.imem_resp_valid ? CNT_ONE : CNT_ZERO);
         drop_d     = inflight_q - (bus.imem_resp_valid ? CNT_ONE : CNT_ZERO);
      end else begin
         if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         inflight_d = inflight_q + (req_fire_s ? CNT_ONE : CNT_ZERO)
                                 - (bus.imem_resp_valid ? CNT_ONE : CNT_ZERO);
         if (bus.imem_resp_valid && (drop_q != CNT_ZERO)) begin
            drop_d = drop_q - CNT_ONE;
         end else begin
            drop_d = drop_q;
         end
         if (resp_keep_s) begin
            resp_pc_d = resp_pc_q + 32'd4;
         end else begin
            resp_pc_d = resp_pc_q;
         end
         if (push_s) begin
            pc_mem_d[wr_ptr_q]    = resp_pc_q;
            instr_mem_d[wr_ptr_q] = bus.imem_resp_data;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         rd_ptr_q   <= PTR_ZERO;
         wr_ptr_q   <= PTR_ZERO;
         count_q    <= CNT_ZERO;
         inflight_q <= CNT_ZERO;
         drop_q     <= CNT_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= 32'h0000_0000;
            instr_mem_q[i] <= 32'h0000_0000;
         end
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         resp_pc_q   <= resp_pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         drop_q      <= drop_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

   assign bus.imem_req_valid = req_valid_s;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.if_valid       = if_valid_s;
   assign bus.if_pc          = if_pc_s;
   assign bus.if_instr       = if_instr_s;

   push_at_full_a: assert property (@(posedge clk) disable iff (reset)
                                    !(push_s && (count_q == DEPTH_CNT)));
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: fill, back-pressure, redirect drop, reset, bypass latency.
// A cycle-stepped memory model answers requests in order after a fixed latency.
module tb_fetch_prefetch_queue;
   localparam bit BYP =
`ifdef PFQ_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_prefetch_queue_if bus_if ();

   fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          lat         = 1;
   bit          mem_hold    = 1'b0;
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   function automatic logic [31:0] img(input logic [31:0] a);
      return 32'h0050_0093 + (a << 10);
   endfunction

   // Present the memory response for the current cycle and let outputs settle.
   task automatic settle();
      if (!mem_hold && (mq_addr.size() > 0) && (mq_due[0] <= cyc)) begin
         bus_if.imem_resp_valid = 1'b1;
         bus_if.imem_resp_data  = img(mq_addr[0]);
      end else begin
         bus_if.imem_resp_valid = 1'b0;
         bus_if.imem_resp_data  = 32'h0000_0000;
      end
      #1;
   endtask

   task automatic tick();
      if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
         mq_addr.push_back(bus_if.imem_req_addr);
         mq_due.push_back(cyc + lat);
      end
      if (bus_if.imem_resp_valid) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus_if.imem_req_ready  = 1'b1;
      bus_if.imem_resp_valid = 1'b0;
      bus_if.imem_resp_data  = 32'h0000_0000;
      bus_if.redirect_valid  = 1'b0;
      bus_if.redirect_pc     = 32'h0000_0000;
      bus_if.if_ready        = 1'b1;
      mem_hold = 1'b0;
      mq_addr.delete();
      mq_due.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic test_fill();
      bit exp_v;
      do_reset();
      settle();
      vectors++;
      if ({bus_if.imem_req_valid, bus_if.imem_req_addr} !== {1'b1, 32'h0000_0000}) begin
         miscompares++;
         $display("FAIL fill_first_req: got v=%b addr=%h, want v=1 addr=00000000", bus_if.imem_req_valid, bus_if.imem_req_addr);
      end
      tick();
      for (int c = 1; c <= 5; c++) begin
         settle();
         exp_v = (c >= (BYP ? 1 : 2));
         vectors++;
         if (bus_if.if_valid !== exp_v) begin
            miscompares++;
            $display("FAIL fill_valid_c%0d: got %b, want %b", c, bus_if.if_valid, exp_v);
         end
         if (exp_v) begin
            vectors++;
            if ({bus_if.if_pc, bus_if.if_instr} !== {32'(4 * (c - (BYP ? 1 : 2))), img(32'(4 * (c - (BYP ? 1 : 2))))}) begin
               miscompares++;
               $display("FAIL fill_entry_c%0d: got pc=%h instr=%h, want pc=%h", c, bus_if.if_pc, bus_if.if_instr, 32'(4 * (c - (BYP ? 1 : 2))));
            end
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mq_addr.delete();
      mq_due.delete();
      bus_if.imem_resp_valid = 1'b0;
      #1;
      vectors++;
      if ({bus_if.imem_req_valid, bus_if.if_valid, bus_if.imem_req_addr, bus_if.if_pc, bus_if.if_instr} !== 99'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got req_v=%b if_v=%b addr=%h pc=%h instr=%h, want all 0",
                  bus_if.imem_req_valid, bus_if.if_valid, bus_if.imem_req_addr, bus_if.if_pc, bus_if.if_instr);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic test_backpressure();
      do_reset();
      bus_if.if_ready = 1'b0;
      for (int c = 0; c <= 5; c++) begin
         settle();
         if (c >= 4) begin
            vectors++;
            if (bus_if.imem_req_valid !== 1'b0) begin
               miscompares++;
               $display("FAIL bp_credit_c%0d: got req_valid=%b, want 0", c, bus_if.imem_req_valid);
            end
         end
         tick();
      end
      bus_if.if_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         vectors++;
         if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_instr} !== {1'b1, 32'(4 * k), img(32'(4 * k))}) begin
            miscompares++;
            $display("FAIL bp_pop%0d: got v=%b pc=%h instr=%h, want pc=%h", k, bus_if.if_valid, bus_if.if_pc, bus_if.if_instr, 32'(4 * k));
         end
         if (k == 1) begin
            vectors++;
            if ({bus_if.imem_req_valid, bus_if.imem_req_addr} !== {1'b1, 32'h0000_0010}) begin
               miscompares++;
               $display("FAIL bp_resume: got v=%b addr=%h, want v=1 addr=00000010", bus_if.imem_req_valid, bus_if.imem_req_addr);
            end
         end
         tick();
      end
   endtask

   task automatic test_redirect_drop();
      do_reset();
      mem_hold = 1'b1;
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'h0000_0020;
      settle();
      tick();
      bus_if.redirect_valid = 1'b0;
      settle();
      vectors++;
      if ({bus_if.imem_req_valid, bus_if.imem_req_addr} !== {1'b1, 32'h0000_0020}) begin
         miscompares++;
         $display("FAIL rd_req20: got v=%b addr=%h, want v=1 addr=00000020", bus_if.imem_req_valid, bus_if.imem_req_addr);
      end
      tick();
      settle();
      tick();
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'h0000_0103;
      settle();
      vectors++;
      if ({bus_if.imem_req_valid, bus_if.if_valid} !== 2'b00) begin
         miscompares++;
         $display("FAIL rd_cycle: got req_v=%b if_v=%b, want 0 0", bus_if.imem_req_valid, bus_if.if_valid);
      end
      tick();
      bus_if.redirect_valid = 1'b0;
      mem_hold = 1'b0;
      settle();
      vectors++;
      if ({bus_if.imem_req_valid, bus_if.imem_req_addr} !== {1'b1, 32'h0000_0100}) begin
         miscompares++;
         $display("FAIL rd_req100: got v=%b addr=%h, want v=1 addr=00000100", bus_if.imem_req_valid, bus_if.imem_req_addr);
      end
      tick();
      bus_if.if_ready = 1'b0;
      settle();
      vectors++;
      if (bus_if.if_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rd_drop2: got if_valid=%b, want 0", bus_if.if_valid);
      end
      tick();
      settle();
      vectors++;
      if (bus_if.if_valid !== BYP) begin
         miscompares++;
         $display("FAIL rd_first_resp: got if_valid=%b, want %b", bus_if.if_valid, BYP);
      end
      tick();
      settle();
      vectors++;
      if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_instr} !== {1'b1, 32'h0000_0100, img(32'h0000_0100)}) begin
         miscompares++;
         $display("FAIL rd_first_pc: got v=%b pc=%h instr=%h, want v=1 pc=00000100", bus_if.if_valid, bus_if.if_pc, bus_if.if_instr);
      end
      tick();
   endtask

   task automatic test_redirect_with_resp();
      do_reset();
      bus_if.if_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         tick();
      end
      bus_if.if_ready       = 1'b1;
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'h0000_0040;
      settle();
      vectors++;
      if ({bus_if.imem_resp_valid, bus_if.if_valid, bus_if.imem_req_valid} !== 3'b100) begin
         miscompares++;
         $display("FAIL rr_cycle: got resp_v=%b if_v=%b req_v=%b, want 1 0 0", bus_if.imem_resp_valid, bus_if.if_valid, bus_if.imem_req_valid);
      end
      tick();
      bus_if.redirect_valid = 1'b0;
      bus_if.if_ready       = 1'b0;
      settle();
      vectors++;
      if ({bus_if.if_valid, bus_if.imem_req_valid, bus_if.imem_req_addr} !== {2'b01, 32'h0000_0040}) begin
         miscompares++;
         $display("FAIL rr_empty: got if_v=%b req_v=%b addr=%h, want 0 1 00000040", bus_if.if_valid, bus_if.imem_req_valid, bus_if.imem_req_addr);
      end
      tick();
      settle();
      tick();
      settle();
      vectors++;
      if ({bus_if.if_valid, bus_if.if_pc} !== {1'b1, 32'h0000_0040}) begin
         miscompares++;
         $display("FAIL rr_restart: got v=%b pc=%h, want v=1 pc=00000040", bus_if.if_valid, bus_if.if_pc);
      end
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      bus_if.if_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         settle();
         tick();
      end
      settle();
      vectors++;
      if ({bus_if.if_valid, bus_if.imem_req_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL ar_pre: got if_v=%b req_v=%b, want 1 0", bus_if.if_valid, bus_if.imem_req_valid);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (bus_if.if_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ar_immediate: got if_valid=%b, want 0", bus_if.if_valid);
      end
      mq_addr.delete();
      mq_due.delete();
      bus_if.imem_resp_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
      settle();
      vectors++;
      if ({bus_if.imem_req_valid, bus_if.imem_req_addr, bus_if.if_valid} !== {1'b1, 32'h0000_0000, 1'b0}) begin
         miscompares++;
         $display("FAIL ar_restart: got req_v=%b addr=%h if_v=%b, want 1 00000000 0", bus_if.imem_req_valid, bus_if.imem_req_addr, bus_if.if_valid);
      end
      tick();
      settle();
      tick();
      settle();
      vectors++;
      if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_instr} !== {1'b1, 32'h0000_0000, img(32'h0000_0000)}) begin
         miscompares++;
         $display("FAIL ar_first: got v=%b pc=%h instr=%h, want v=1 pc=00000000", bus_if.if_valid, bus_if.if_pc, bus_if.if_instr);
      end
      tick();
   endtask

   task automatic test_bypass_latency();
      do_reset();
      settle();
      tick();
      bus_if.imem_req_ready = 1'b0;
      settle();
      vectors++;
      if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_instr} !== {BYP, 32'h0000_0000, (BYP ? 32'h0050_0093 : 32'h0000_0000)}) begin
         miscompares++;
         $display("FAIL byp_resp_cycle: got v=%b pc=%h instr=%h, want v=%b", bus_if.if_valid, bus_if.if_pc, bus_if.if_instr, BYP);
      end
      tick();
      settle();
      vectors++;
      if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_instr} !== {!BYP, 32'h0000_0000, (BYP ? 32'h0000_0000 : 32'h0050_0093)}) begin
         miscompares++;
         $display("FAIL byp_next_cycle: got v=%b pc=%h instr=%h, want v=%b", bus_if.if_valid, bus_if.if_pc, bus_if.if_instr, !BYP);
      end
      tick();
   endtask

   initial begin
      test_fill();
      test_reset();
      test_backpressure();
      test_redirect_drop();
      test_redirect_with_resp();
      test_async_reset();
      test_bypass_latency();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
